// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit
//
// Purpose: takes the two register-file operands of an M-extension op, runs a
// 32-step shift-add multiply or restoring divide on operand magnitudes, then
// fixes up signs and returns the result with its destination register and a
// one-cycle write strobe. Divide-by-zero and signed overflow finish without
// entering RUN.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           issue request, sampled only in IDLE
//   funct3          op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_data        dividend / multiplicand
//   rs2_data        divisor / multiplier
//   rd_in           destination register index
//   busy            high in RUN and DONE, the core stalls on it
//   done            one-cycle pulse, result and rd_out valid
//   reg_write       register-file write enable, equal to done
//   result          computed value, held after DONE
//   rd_out          destination index held with result

module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            reg_write,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int W = XLEN;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   opnd_q, opnd_d;     // multiplicand (mul) or divisor (div) magnitude
  logic [2*W-1:0] acc_q, acc_d;       // mul: {high, multiplier/low}; div: low half is dividend/quotient
  logic [W-1:0]   rem_q, rem_d;       // partial remainder
  logic           neg1_q, neg1_d;
  logic           neg2_q, neg2_d;
  logic [4:0]     rd_cap_q, rd_cap_d;
  logic [W-1:0]   result_q, result_d;
  logic [4:0]     rd_q, rd_d;

  // Incoming operand decode
  logic         s1_signed, s2_signed, in_neg1, in_neg2;
  logic [W-1:0] mag1, mag2, fast_res;
  logic         div_zero, div_ovf;

  assign s1_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
  assign s2_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign in_neg1   = s1_signed & rs1_data[W-1];
  assign in_neg2   = s2_signed & rs2_data[W-1];
  assign mag1      = in_neg1 ? (~rs1_data + 1'b1) : rs1_data;
  assign mag2      = in_neg2 ? (~rs2_data + 1'b1) : rs2_data;
  assign div_zero  = funct3[2] && (rs2_data == '0);
  assign div_ovf   = funct3[2] && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
  // Divide-by-zero takes priority over overflow
  assign fast_res  = div_zero ? (funct3[1] ? rs1_data : '1)
                              : (funct3[1] ? '0 : MIN_NEG);

  // One shift-add step: add multiplicand to the high half if the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_acc;
  assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc = {mul_sum, acc_q[W-1:1]};

  // One restoring-division step: the 33-bit trial difference borrows into
  // bit W exactly when the shifted remainder is below the divisor.
  logic [W:0]   div_shift, div_diff;
  logic         div_ok;
  logic [W-1:0] div_rem, div_quo;
  assign div_shift = {rem_q, acc_q[W-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ok    = ~div_diff[W];
  assign div_rem   = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
  assign div_quo   = {acc_q[W-2:0], div_ok};

  // Sign fix-up applied to the values of the final step
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s, rem_s, fin_res;
  assign prod_s  = (neg1_q ^ neg2_q) ? (~mul_acc + 1'b1) : mul_acc;
  assign quo_s   = (neg1_q ^ neg2_q) ? (~div_quo + 1'b1) : div_quo;
  assign rem_s   = neg1_q ? (~div_rem + 1'b1) : div_rem;
  assign fin_res = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                           : ((op_q == 3'b000) ? prod_s[W-1:0] : prod_s[2*W-1:W]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    rd_cap_d = rd_cap_q;
    result_d = result_q;
    rd_d     = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = funct3;
          neg1_d   = in_neg1;
          neg2_d   = in_neg2;
          rd_cap_d = rd_in;
          cnt_d    = '0;
          rem_d    = '0;
          opnd_d   = funct3[2] ? mag2 : mag1;
          acc_d    = {{W{1'b0}}, (funct3[2] ? mag1 : mag2)};
          if (div_zero || div_ovf) begin
            result_d = fast_res;
            rd_d     = rd_in;
            state_d  = S_DONE;
          end else begin
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (op_q[2]) begin
          acc_d = {{W{1'b0}}, div_quo};
          rem_d = div_rem;
        end else begin
          acc_d = mul_acc;
        end
        if (cnt_q == 6'(W-1)) begin
          result_d = fin_res;
          rd_d     = rd_cap_q;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      rd_cap_q <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      rd_cap_q <= rd_cap_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign reg_write = done;
  assign result    = result_q;
  assign rd_out    = rd_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard testbench for mdu_iter

module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done, reg_write;
  logic [31:0] result;
  logic [4:0]  rd_out;

  mdu_iter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .reg_write(reg_write),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    int          issue;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (done === 1'b1) begin
        chk("reg_write_eq_done", {31'b0, reg_write}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
          chk("done_latency", cyc - e.issue, e.lat);
        end
      end else if (reg_write !== 1'b0) begin
        chk("reg_write_without_done", {31'b0, reg_write}, 32'd0);
      end
    end
  end

  // Called at a negedge while idle; returns at the negedge of the next cycle.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat);
    exp_t e;
    chk("busy_low_at_start", {31'b0, busy}, 32'd0);
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    e.res = res; e.rd = rd; e.lat = lat; e.issue = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
  endtask

  // Counts busy cycles until IDLE is observed, bounded.
  task automatic wait_idle(input int exp_busy);
    int n = 0;
    int guard = 0;
    while (busy === 1'b1 && guard < 200) begin
      n++; guard++;
      @(negedge clk);
    end
    if (guard >= 200) chk("idle_timeout", 32'd1, 32'd0);
    chk("busy_cycles", n, exp_busy);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] res, input int lat);
    issue(f, a, b, rd, res, lat);
    wait_idle(lat);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_reg_write", {31'b0, reg_write}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd_out", {27'b0, rd_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(F_MUL,    32'd81,        32'd57,        5'd5,  32'd4617,      33);
    run(F_MUL,    32'hFFFFFFFD,  32'd7,         5'd6,  32'hFFFFFFEB,  33);
    run(F_MULH,   32'hFFFFFFFE,  32'd3,         5'd7,  32'hFFFFFFFF,  33);
    run(F_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,  5'd8,  32'hFFFFFFFE,  33);
    run(F_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd9,  32'hFFFFFFFF,  33);
    run(F_DIV,    32'hFFFFFFF9,  32'd2,         5'd10, 32'hFFFFFFFD,  33);
    run(F_REM,    32'hFFFFFFF9,  32'd2,         5'd11, 32'hFFFFFFFF,  33);
    run(F_DIV,    32'd7,         32'hFFFFFFFE,  5'd12, 32'hFFFFFFFD,  33);
    run(F_REM,    32'd7,         32'hFFFFFFFE,  5'd13, 32'd1,         33);
    run(F_DIVU,   32'd100,       32'd8,         5'd14, 32'd12,        33);
    run(F_REMU,   32'd100,       32'd8,         5'd15, 32'd4,         33);
    run(F_DIVU,   32'd100,       32'd0,         5'd16, 32'hFFFFFFFF,  1);
    run(F_REM,    32'd100,       32'd0,         5'd17, 32'd100,       1);
    run(F_DIV,    32'h80000000,  32'hFFFFFFFF,  5'd18, 32'h80000000,  1);
    run(F_REM,    32'h80000000,  32'hFFFFFFFF,  5'd19, 32'd0,         1);
    chk("result_held", result, 32'd0);

    // start pulsed in cycle 10 of a running op is ignored
    issue(F_MUL, 32'd81, 32'd57, 5'd20, 32'd4617, 33);
    repeat (9) @(negedge clk);
    start = 1'b1; funct3 = F_DIVU; rs1_data = 32'd50; rs2_data = 32'd0; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0;
    wait_idle(23);

    // reset in cycle 15 aborts the op with no done
    issue(F_MULHU, 32'h12345678, 32'h9ABCDEF0, 5'd21, 32'd0, 33);
    void'(exp_q.pop_back());
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_rd_out", {27'b0, rd_out}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run(F_DIVU, 32'd99, 32'd9, 5'd22, 32'd11, 33);

    // rst and start together: reset wins
    rst = 1'b1; start = 1'b1; funct3 = F_DIVU; rs1_data = 32'd1; rs2_data = 32'd0; rd_in = 5'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("rst_start_not_accepted", {31'b0, busy}, 32'd0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
